// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time, low time and period of each complete cycle on an asynchronous PWM line.
// Optional build macro PWM_CAP_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module pwm_capture #(
  parameter int CW   = 16,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic [CW-1:0] period,
  output logic          meas_valid,
  output logic          timeout
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int FILL = SYNC + 4;
`else
  localparam int FILL = SYNC + 1;
`endif

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [SYNC-1:0] sync_reg;
  logic [FILL-1:0] fill_reg;
  logic            s_raw;
  logic            s;
  logic            s_d_reg;
  logic            primed;
  logic            rise;
  logic            fall;

  logic [CW-1:0]   hcnt_reg, hcnt_next;
  logic [CW-1:0]   lcnt_reg, lcnt_next;
  logic [CW-1:0]   high_reg, high_next;
  logic [CW-1:0]   low_reg, low_next;
  logic [CW-1:0]   period_reg, period_next;
  logic            valid_reg, valid_next;
  logic            timeout_reg, timeout_next;
  logic [CW:0]     period_sum;
  logic [CW-1:0]   period_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], pwm_in};
    end
  end

  assign s_raw = sync_reg[SYNC-1];

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic [2:0] hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 3'b000;
    end else begin
      hist_reg <= {hist_reg[1:0], s_raw};
    end
  end

  assign s = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
             (hist_reg[1] & hist_reg[2]);
`else
  assign s = s_raw;
`endif

  // The cleared pipeline is not a real sample of the line: edges are ignored until
  // s_d holds a genuine sample, so a line already high at reset release is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d_reg  <= 1'b0;
      fill_reg <= '0;
    end else begin
      s_d_reg  <= s;
      fill_reg <= {fill_reg[FILL-2:0], 1'b1};
    end
  end

  assign primed = fill_reg[FILL-1];
  assign rise   = primed & s & ~s_d_reg;
  assign fall   = primed & ~s & s_d_reg;

  assign period_sum = {1'b0, hcnt_reg} + {1'b0, lcnt_reg};
  assign period_sat = period_sum[CW] ? CNT_MAX : period_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= SEEK;
      hcnt_reg    <= '0;
      lcnt_reg    <= '0;
      high_reg    <= '0;
      low_reg     <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hcnt_reg    <= hcnt_next;
      lcnt_reg    <= lcnt_next;
      high_reg    <= high_next;
      low_reg     <= low_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hcnt_next    = hcnt_reg;
    lcnt_next    = lcnt_reg;
    high_next    = high_reg;
    low_next     = low_reg;
    period_next  = period_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;

    case (state_reg)
      SEEK: begin
        if (rise) begin
          state_next = HIGH;
          hcnt_next  = CW'(1);
          lcnt_next  = '0;
        end
      end

      HIGH: begin
        if (fall) begin
          state_next = LOW;
          lcnt_next  = CW'(1);
        end else if (hcnt_reg == CNT_MAX) begin
          state_next   = SEEK;
          hcnt_next    = '0;
          lcnt_next    = '0;
          timeout_next = 1'b1;
        end else begin
          hcnt_next = hcnt_reg + CW'(1);
        end
      end

      LOW: begin
        // A rise takes priority over saturation; the saturated count is published.
        if (rise) begin
          high_next    = hcnt_reg;
          low_next     = lcnt_reg;
          period_next  = period_sat;
          valid_next   = 1'b1;
          timeout_next = 1'b0;
          state_next   = HIGH;
          hcnt_next    = CW'(1);
          lcnt_next    = '0;
        end else if (lcnt_reg == CNT_MAX) begin
          state_next   = SEEK;
          hcnt_next    = '0;
          lcnt_next    = '0;
          timeout_next = 1'b1;
        end else begin
          lcnt_next = lcnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = SEEK;
        hcnt_next  = '0;
        lcnt_next  = '0;
      end
    endcase
  end

  assign high_time  = high_reg;
  assign low_time   = low_reg;
  assign period     = period_reg;
  assign meas_valid = valid_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: a CW=10 instance fed by an 8-bit PWM generator model
// or direct drive, and a CW=4 instance for the saturation and timeout boundaries.
module tb_pwm_capture;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_a = 1'b0;
  logic       pwm_b = 1'b0;
  logic [9:0] high_time, low_time, period;
  logic       meas_valid, timeout;
  logic [3:0] high4, low4, period4;
  logic       mv4, timeout4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mv_count = 0;
  int last_mv_cyc = 0;
  int prev_mv_cyc = 0;
  int mv4_count = 0;
  int rise_cnt = 0;
  logic [7:0] gen_cnt = 8'd0;
  logic [7:0] duty = 8'd0;

  always #5 clk = ~clk;

  pwm_capture #(.CW(10), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_a),
    .high_time(high_time), .low_time(low_time), .period(period),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  pwm_capture #(.CW(4), .SYNC(2)) dut4 (
    .clk(clk), .rst(rst), .pwm_in(pwm_b),
    .high_time(high4), .low_time(low4), .period(period4),
    .meas_valid(mv4), .timeout(timeout4)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) begin
      mv_count++;
      prev_mv_cyc = last_mv_cyc;
      last_mv_cyc = cyc;
    end
    if (mv4) mv4_count++;
  endtask

  task automatic gen_step();
    logic nxt;
    nxt = (gen_cnt >= duty);
    if (nxt && !pwm_a) rise_cnt++;
    pwm_a = nxt;
    gen_cnt = gen_cnt + 8'd1;
    tick();
  endtask

  task automatic drive_b(input logic lvl, input int n);
    pwm_b = lvl;
    repeat (n) tick();
  endtask

  initial begin
    int base;
    int mixed;
    int good;
    int to_low;
    int drive_cyc;
    int first_mv;

    // Reset state
    rst = 1'b1;
    repeat (4) tick();
    check("rst_high_time", int'(high_time), 0);
    check("rst_low_time", int'(low_time), 0);
    check("rst_period", int'(period), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_timeout4", int'(timeout4), 0);
    rst = 1'b0;

    // Test 1: duty 64, five periods, first partial period discarded
    gen_cnt = 8'd0;
    duty = 8'd64;
    base = mv_count;
    repeat (1280) gen_step();
    check("t1_strobe_count", mv_count - base, 4);
    check("t1_strobe_interval", last_mv_cyc - prev_mv_cyc, 256);
    check("t1_high_time", int'(high_time), 192);
    check("t1_low_time", int'(low_time), 64);
    check("t1_period", int'(period), 256);

    // Test 2: duty 64 -> 200 mid-period
    repeat (100) gen_step();
    duty = 8'd200;
    mixed = 0;
    good = 0;
    repeat (1024) begin
      gen_step();
      if (meas_valid) begin
        if (high_time == 10'd56 && low_time == 10'd200 && period == 10'd256) good++;
        else mixed++;
      end
    end
    check("t2_mixed_at_most_1", int'(mixed <= 1), 1);
    check("t2_good_results", good, 3);
    check("t2_high_time", int'(high_time), 56);
    check("t2_low_time", int'(low_time), 200);
    check("t2_period", int'(period), 256);

    // Test 3: line stuck high, then recovery at duty 128
    duty = 8'd0;
    for (int i = 0; i < 1500 && !timeout; i++) gen_step();
    check("t3_timeout_set", int'(timeout), 1);
    check("t3_timeout_delay", cyc - last_mv_cyc, 1023);
    base = mv_count;
    repeat (200) gen_step();
    check("t3_no_strobe_stuck", mv_count - base, 0);
    check("t3_timeout_held", int'(timeout), 1);
    duty = 8'd128;
    rise_cnt = 0;
    to_low = 0;
    base = mv_count;
    for (int i = 0; i < 800 && mv_count == base; i++) begin
      gen_step();
      if (mv_count == base && !timeout) to_low = 1;
    end
    check("t3_recover_strobe", mv_count - base, 1);
    check("t3_recover_on_rise", rise_cnt, 2);
    check("t3_timeout_until_publish", to_low, 0);
    check("t3_high_time", int'(high_time), 128);
    check("t3_low_time", int'(low_time), 128);
    check("t3_period", int'(period), 256);
    check("t3_timeout_cleared", int'(timeout), 0);

    // Test 4: reset for one clock while the line is high
    while (gen_cnt != 8'd150) gen_step();
    rst = 1'b1;
    gen_step();
    check("t4_high_time_zero", int'(high_time), 0);
    check("t4_low_time_zero", int'(low_time), 0);
    check("t4_period_zero", int'(period), 0);
    check("t4_meas_valid_zero", int'(meas_valid), 0);
    rst = 1'b0;
    base = mv_count;
    repeat (300) gen_step();
    check("t4_first_period_dropped", mv_count - base, 0);
    for (int i = 0; i < 400 && mv_count == base; i++) gen_step();
    check("t4_strobe_after", mv_count - base, 1);
    check("t4_high_time", int'(high_time), 128);
    check("t4_low_time", int'(low_time), 128);
    check("t4_period", int'(period), 256);

    // Test 5: direct drive, high 1 / low 5
    pwm_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    base = mv_count;
    drive_cyc = 0;
    first_mv = 0;
    for (int r = 0; r < 10; r++) begin
      if (r == 1) drive_cyc = cyc;
      pwm_a = 1'b1;
      tick();
      if (meas_valid && first_mv == 0) first_mv = cyc;
      pwm_a = 1'b0;
      repeat (5) begin
        tick();
        if (meas_valid && first_mv == 0) first_mv = cyc;
      end
    end
    repeat (5) tick();
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("t5_filtered_no_strobe", mv_count - base, 0);
`else
    check("t5_strobe_count", mv_count - base, 9);
    check("t5_latency", first_mv - drive_cyc, LAT);
    check("t5_high_time", int'(high_time), 1);
    check("t5_low_time", int'(low_time), 5);
    check("t5_period", int'(period), 6);
`endif

    // Test 6: CW=4 saturation and timeout boundaries
    base = mv4_count;
    drive_b(1'b1, 2);
    drive_b(1'b0, 2);
    drive_b(1'b1, 15);
    drive_b(1'b0, 3);
    drive_b(1'b1, 10);
    check("t6_h15_high_time", int'(high4), 15);
    check("t6_h15_low_time", int'(low4), 3);
    check("t6_h15_period_sat", int'(period4), 15);
    check("t6_h15_no_timeout", int'(timeout4), 0);
    drive_b(1'b0, 10);
    drive_b(1'b1, 10);
    check("t6_10_high_time", int'(high4), 10);
    check("t6_10_low_time", int'(low4), 10);
    check("t6_10_period_sat", int'(period4), 15);
    drive_b(1'b0, 10);
    drive_b(1'b1, 16);
    drive_b(1'b0, 10);
    check("t6_h16_timeout", int'(timeout4), 1);
    check("t6_h16_result_held", int'(high4), 10);
    check("t6_strobe_count", mv4_count - base, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
